ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit for the single-cycle LEGv8 core. It holds the program counter, drives the word address into the combinational instruction memory and captures each returned word with its PC into a 2-entry buffer. It presents the buffered instructions to decode over a valid/ready handshake. It is the reading end of the instruction-memory interface and also handles branch redirect.

## Interface
- DATA_WIDTH, 32, instruction word width
- N, 64, PC width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  6  word address to instruction memory, always equal to pc[7:2]
- imem_q  in  DATA_WIDTH  instruction word from memory, combinational in imem_addr
- br_taken  in  1  redirect request, sampled each rising edge
- br_target  in  N  redirect byte address; bits [1:0] are ignored and forced to 0
- out_valid  out  1  head buffer entry is valid
- out_ready  in  1  decode accepts the head entry
- out_instr  out  DATA_WIDTH  instruction at the buffer head
- out_pc  out  N  byte address of out_instr
- halted  out  1  fetch is in HALT; always 0 when the halt feature is compiled out

## Operation
- State: pc (N bits), 2-entry FIFO of {pc, instr}, count (0..2), FSM with states RUN and HALT.
- pop = out_valid & out_ready.
- space = (count < 2) | pop.
- Cycle action, evaluated in priority order:
  - br_taken: FIFO flushed (count = 0), pc = {br_target[N-1:2], 2'b00}, FSM = RUN, no push; a simultaneous pop is discarded.
  - FSM = RUN and space: push {pc, imem_q}, pc = pc + 4.
  - Otherwise pc holds and no push occurs.
- Pop and push in the same cycle are both performed, so throughput is 1 instruction per cycle.
- Entries leave the FIFO in program order.
- pc is modulo 2^N. imem_addr uses pc[7:2], so addresses at or above 0x100 alias onto memory words 0..63.
- out_instr and out_pc come from the head entry. They hold stable while out_valid = 1 and out_ready = 0.
- Reset values:
  - pc = 0, count = 0, FSM = RUN
  - out_valid = 0, out_instr = 0, out_pc = 0, halted = 0
  - imem_addr = 0
- Reset asserted mid-operation clears all state immediately. Buffered instructions are lost.

## Timing
- imem_addr changes only on a clock edge: a pc update or reset.
- Fetch latency: the word at pc is pushed on the edge where the push condition holds. out_valid rises on that same edge when the FIFO was empty.
- First instruction: out_valid = 1 after the first rising edge following reset release.
- Redirect penalty: the cycle after the br_taken edge has out_valid = 0. The target instruction appears after the next edge, so there is 1 bubble.
- Back-pressure: with out_ready = 0 the FIFO fills in 2 edges and pc then stalls. After out_ready returns to 1, throughput resumes within 0 extra cycles.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined:
  - A push candidate with imem_q == 0 is not pushed.
  - FSM goes RUN→HALT and pc holds at that address.
  - halted = 1 in HALT. The FIFO keeps draining normally.
  - Only br_taken or reset leaves HALT.
- FETCH_HALT_ON_ZERO_EN not defined:
  - Zero words are fetched and delivered like any other word.
  - The HALT state is unreachable and halted is tied to 0.

## Test plan
- Reset, out_ready = 1, lab program loaded:
  - After the first edge: out_valid = 1, out_pc = 0, out_instr = 32'hf8000000.
  - Next edge: out_pc = 4, out_instr = 32'hf8008001.
  - One instruction is delivered per cycle.
- Back-pressure: out_ready = 0 for 5 cycles.
  - count saturates at 2 and pc stalls at 8.
  - out_instr holds 32'hf8000000.
  - On release, out_pc sequence is 0, 4, 8 with no gaps and no duplicates.
- Redirect: br_taken = 1 with br_target = 0x3A (misaligned) while 2 entries are buffered and out_ready = 1.
  - Flush occurs and the popped entry is dropped.
  - Next cycle out_valid = 0, then out_pc = 0x38 with out_instr = 32'hcb0e01ce.
- Wrap/alias: redirect to 0xFC.
  - Fetched out_pc sequence is 0xFC, 0x100, with imem_addr 63 then 0.
  - Word at 0x100 equals the word at 0.
- Halt, macro defined: run past address 0x48, where memory returns 0.
  - halted = 1 and pc = 0x4C.
  - The last delivered out_instr is 32'hf803800f.
  - A later br_taken to 0 restores delivery.
  - With the macro undefined, the same run delivers instr 0 at out_pc 0x4C and halted stays 0.
- Async reset asserted mid-stream with out_valid = 1: out_valid = 0 and imem_addr = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: program counter, 2-entry {pc, instr} buffer toward decode,
// and branch redirect.
// Optional feature: define FETCH_HALT_ON_ZERO_EN to stop fetching at an all-zero word
// (fetch enters HALT until a redirect or reset).
module ifetch #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N          = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [5:0]            imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_q,
   input  logic                  br_taken,
   input  logic [N-1:0]          br_target,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [N-1:0]          out_pc,
   output logic                  halted
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e                state_q, state_d;
   logic [N-1:0]          pc_q, pc_d;
   logic [N-1:0]          buf_pc_q    [2];
   logic [DATA_WIDTH-1:0] buf_instr_q [2];
   logic                  rd_ptr_q, wr_ptr_q;
   logic [1:0]            count_q, count_d;

   logic pop, space, fetch_en, push, zero_word;

   // Redirect ignores the low two bits of the target.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^br_target[1:0];

   assign imem_addr = pc_q[7:2];
   assign out_valid = (count_q != 2'd0);
   assign out_instr = buf_instr_q[rd_ptr_q];
   assign out_pc    = buf_pc_q[rd_ptr_q];
   assign pop       = out_valid & out_ready;
   assign space     = (count_q < 2'd2) | pop;
   assign zero_word = (imem_q == '0);

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StRun;
      else        state_q <= state_d;
   end

   // FSM next state: redirect always resumes fetching
   always_comb begin
      state_d = state_q;
      if (br_taken) begin
         state_d = StRun;
      end else begin
`ifdef FETCH_HALT_ON_ZERO_EN
         if (state_q == StRun && space && zero_word) state_d = StHalt;
`endif
      end
   end

   // FSM outputs: fetch enable and halted flag
   always_comb begin
      fetch_en = (state_q == StRun) && space && !br_taken;
`ifdef FETCH_HALT_ON_ZERO_EN
      push   = fetch_en && !zero_word;
      halted = (state_q == StHalt);
`else
      push   = fetch_en;
      halted = 1'b0;
`endif
   end

   // Next pc and buffer occupancy; a redirect discards any pop in the same cycle
   always_comb begin
      pc_d    = pc_q;
      count_d = count_q;
      if (br_taken) begin
         pc_d    = {br_target[N-1:2], 2'b00};
         count_d = 2'd0;
      end else begin
         if (push) pc_d = pc_q + N'(4);
         if (push && !pop)      count_d = count_q + 2'd1;
         else if (pop && !push) count_d = count_q - 2'd1;
      end
   end

   // PC and buffer storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= '0;
         count_q  <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_pc_q[i]    <= '0;
            buf_instr_q[i] <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         if (br_taken) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               buf_pc_q[wr_ptr_q]    <= pc_q;
               buf_instr_q[wr_ptr_q] <= imem_q;
               wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed test-plan checks plus randomized redirects and
// back-pressure against a queue-based reference model with a scoreboard monitor.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [31:0] imem_q;
   logic        br_taken;
   logic [63:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        halted;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0] mem [64];
   entry_t      exp_q [$];
   logic [63:0] m_pc;
   bit          m_halt;
   int          errors = 0;
   int          checks = 0;
   int          delivered = 0;

   ifetch #(.DATA_WIDTH(32), .N(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .imem_addr (imem_addr),
      .imem_q    (imem_q),
      .br_taken  (br_taken),
      .br_target (br_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory
   assign imem_q = mem[imem_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs for the coming edge, just after the falling edge
   task automatic cyc(input logic r, input logic b, input logic [63:0] t);
      @(negedge clk);
      #1;
      out_ready = r;
      br_taken  = b;
      br_target = t;
   endtask

   task automatic do_reset(input logic r);
      @(negedge clk);
      #1;
      reset     = 1'b0;
      out_ready = r;
      br_taken  = 1'b0;
      br_target = '0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Scoreboard monitor: compares the presented head against the expected stream
   always @(negedge clk) begin
      #3;
      if (reset === 1'b1) begin
         chk("mon_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("mon_pc", out_pc, exp_q[0].pc);
            chk("mon_instr", 64'(out_instr), 64'(exp_q[0].instr));
         end
         chk("mon_imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
         chk("mon_halted", 64'(halted), 64'(m_halt));
         if (out_valid && out_ready && !br_taken && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            delivered++;
         end
      end
   end

   // Reference model: decides what the coming edge fetches (after the monitor's pop)
   always @(negedge clk) begin
      logic [31:0] w;
      #4;
      if (reset !== 1'b1) begin
         exp_q.delete();
         m_pc   = '0;
         m_halt = 1'b0;
      end else if (br_taken) begin
         exp_q.delete();
         m_pc   = br_target & ~64'h3;
         m_halt = 1'b0;
      end else if (!m_halt && exp_q.size() < 2) begin
         w = mem[m_pc[7:2]];
`ifdef FETCH_HALT_ON_ZERO_EN
         if (w == 32'h0) begin
            m_halt = 1'b1;
         end else begin
            exp_q.push_back('{pc: m_pc, instr: w});
            m_pc = m_pc + 64'd4;
         end
`else
         exp_q.push_back('{pc: m_pc, instr: w});
         m_pc = m_pc + 64'd4;
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] t;
      for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
      mem[0]  = 32'hf8000000;
      mem[1]  = 32'hf8008001;
      mem[14] = 32'hcb0e01ce;
      mem[18] = 32'hf803800f;
      mem[19] = 32'h0;
      reset     = 1'b0;
      out_ready = 1'b1;
      br_taken  = 1'b0;
      br_target = '0;
      m_pc      = '0;
      m_halt    = 1'b0;

      // Reset values
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);

      // Streaming from reset
      do_reset(1'b1);
      cyc(1, 0, 0);
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_pc", out_pc, 64'h0);
      chk("first_instr", 64'(out_instr), 64'hf8000000);
      cyc(1, 0, 0);
      chk("second_pc", out_pc, 64'h4);
      chk("second_instr", 64'(out_instr), 64'hf8008001);

      // Back-pressure
      do_reset(1'b0);
      repeat (5) cyc(0, 0, 0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_instr", 64'(out_instr), 64'hf8000000);
      chk("bp_pc_stall", 64'(imem_addr), 64'd2);
      cyc(1, 0, 0);
      chk("bp_rel0", out_pc, 64'h0);
      cyc(1, 0, 0);
      chk("bp_rel4", out_pc, 64'h4);
      cyc(1, 0, 0);
      chk("bp_rel8", out_pc, 64'h8);

      // Redirect with a full buffer and a simultaneous pop
      repeat (2) cyc(0, 0, 0);
      cyc(1, 1, 64'h3a);
      cyc(1, 0, 0);
      chk("br_bubble", 64'(out_valid), 64'd0);
      chk("br_imem_addr", 64'(imem_addr), 64'd14);
      cyc(1, 0, 0);
      chk("br_valid", 64'(out_valid), 64'd1);
      chk("br_pc", out_pc, 64'h38);
      chk("br_instr", 64'(out_instr), 64'hcb0e01ce);

      // Wrap / alias
      cyc(1, 1, 64'hfc);
      cyc(1, 0, 0);
      chk("wrap_imem63", 64'(imem_addr), 64'd63);
      cyc(1, 0, 0);
      chk("wrap_pc_fc", out_pc, 64'hfc);
      chk("wrap_imem0", 64'(imem_addr), 64'd0);
      cyc(1, 0, 0);
      chk("wrap_pc_100", out_pc, 64'h100);
      chk("wrap_alias", 64'(out_instr), 64'hf8000000);

      // Zero word at 0x4C
      cyc(1, 1, 64'h40);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("z_pc40", out_pc, 64'h40);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("z_pc48", out_pc, 64'h48);
      chk("z_instr48", 64'(out_instr), 64'hf803800f);
      cyc(1, 0, 0);
`ifdef FETCH_HALT_ON_ZERO_EN
      chk("halt_valid", 64'(out_valid), 64'd0);
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_imem", 64'(imem_addr), 64'd19);
      repeat (3) cyc(1, 0, 0);
      chk("halt_hold", 64'(halted), 64'd1);
      cyc(1, 1, 64'h0);
      cyc(1, 0, 0);
      chk("unhalt_flag", 64'(halted), 64'd0);
      cyc(1, 0, 0);
      chk("unhalt_valid", 64'(out_valid), 64'd1);
      chk("unhalt_pc", out_pc, 64'h0);
`else
      chk("zero_pc", out_pc, 64'h4c);
      chk("zero_instr", 64'(out_instr), 64'h0);
      chk("zero_halted", 64'(halted), 64'd0);
      cyc(1, 0, 0);
`endif

      // Asynchronous reset mid-stream
      cyc(1, 0, 0);
      chk("pre_async_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_imem", 64'(imem_addr), 64'd0);
      chk("async_halted", 64'(halted), 64'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;

      // Randomized back-pressure and redirects
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       t = {$urandom, $urandom};
            1:       t = 64'hffff_ffff_ffff_fff9 - 64'($urandom_range(0, 16));
            default: t = 64'($urandom_range(0, 511));
         endcase
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, t);
      end
      cyc(1, 0, 0);
      chk("delivered_enough", 64'(delivered > 100), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
